// File: rtl/sig_gate_counter_pkg.sv
// Shared types and default sizing for the frequency-counter front end and its readout block.
package sfc_pkg;

    typedef enum logic {
        IDLE,
        GATE
    } state_e;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned GATE_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/sig_gate_counter_if.sv
// Result channel of the gated edge counter: captured count plus valid/ready handshake.
interface sig_gate_counter_if
    import sfc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic [CNT_W-1:0] COUNT;
    logic             COUNT_OVF;
    logic             COUNT_VALID;
    logic             COUNT_READY;

    modport master (
        output COUNT,
        output COUNT_OVF,
        output COUNT_VALID,
        input  COUNT_READY
    );

    modport slave (
        input  COUNT,
        input  COUNT_OVF,
        input  COUNT_VALID,
        output COUNT_READY
    );

endinterface

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sig_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/sig_gate_counter.sv
// Gated edge counter: counts synchronised rising edges of SIG_IN over GATE_CYCLES clocks,
// single-shot or back-to-back, and hands each result to the readout over valid/ready.
module sig_gate_counter
    import sfc_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SIG_IN,
    input  logic                START,
    input  logic                CONTINUOUS,
    sig_gate_counter_if.master  res,
    output logic                MISSED,
    output logic                BUSY
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] EDGE_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] EDGE_MAX  = '1;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d, edge_nx;
    logic             ovf_q, ovf_d, ovf_nx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cnt_ovf_q, cnt_ovf_d;
    logic             valid_q, valid_d;
    logic             missed_q, missed_d;
    logic             load;
    logic             rise;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (CLK),
        .rst    (RESET),
        .async_i(SIG_IN),
        .rise   (rise)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            edge_q    <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            cnt_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            cnt_ovf_q <= cnt_ovf_d;
            valid_q   <= valid_d;
            missed_q  <= missed_d;
        end
    end

    // Saturating edge count including this cycle's rise, so the last gate cycle is captured too.
    always_comb begin
        edge_nx = edge_q;
        ovf_nx  = ovf_q;
        if (rise) begin
            if (edge_q == EDGE_MAX) ovf_nx  = 1'b1;
            else                    edge_nx = edge_q + EDGE_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        cnt_ovf_d = cnt_ovf_q;
        valid_d   = valid_q & ~res.COUNT_READY;
        missed_d  = missed_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) missed_d = 1'b0;
                if (START || CONTINUOUS) begin
                    state_d = GATE;
                    load    = 1'b1;
                end
            end
            GATE: begin
                edge_d = edge_nx;
                ovf_d  = ovf_nx;
                gate_d = gate_q - GATE_ONE;
                if (gate_q == '0) begin
                    // A capture overrides a simultaneous handshake.
                    count_d   = edge_nx;
                    cnt_ovf_d = ovf_nx;
                    valid_d   = 1'b1;
                    if (valid_q && !res.COUNT_READY) missed_d = 1'b1;
                    if (CONTINUOUS) load    = 1'b1;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            gate_d = GATE_LOAD;
            edge_d = '0;
            ovf_d  = 1'b0;
        end
    end

    assign res.COUNT       = count_q;
    assign res.COUNT_OVF   = cnt_ovf_q;
    assign res.COUNT_VALID = valid_q;
    assign MISSED          = missed_q;
    assign BUSY            = (state_q == GATE);

endmodule
